risac_mem_arbiter: RTL and testbench

Synthesizable bridge between the risac core's IBUS/DBUS and one single-port synchronous RAM, plus a byte console register. It replaces the zero-latency dual-access bench memory with a realistic one-read-latency shared port, so the core's wait handshakes are exercised. Sits directly downstream of the core and upstream of the RAM macro.

---
 rtl/risac_mem_arbiter.sv | 109 ++++++++++
 tb/tb_risac_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/risac_mem_arbiter.sv
// Shares one single-port synchronous RAM between the core's fetch and data buses,
// and decodes a byte-wide console register. Data accesses win over fetches.
module risac_mem_arbiter #(
    parameter int          MEM_AW       = 12,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       iIbusAddr,
    output logic [31:0]       oIbusData,
    output logic [31:0]       oIbusIAddr,
    output logic              oIbusWait,
    input  logic [31:0]       iDbusAddr,
    input  logic              iDbusWe,
    input  logic [31:0]       iDbusData,
    input  logic              iDbusRead,
    input  logic [3:0]        iDbusByteEn,
    output logic [31:0]       oDbusData,
    output logic              oDbusWait,
    output logic [MEM_AW-3:0] oMemAddr,
    output logic              oMemRe,
    output logic              oMemWe,
    output logic [3:0]        oMemByteEn,
    output logic [31:0]       oMemWData,
    input  logic [31:0]       iMemRData,
    output logic              oConsoleValid,
    output logic [7:0]        oConsoleData
);

    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_IF   = 2'd1;
    localparam logic [1:0] RSP_DRD  = 2'd2;

    logic [1:0]  rsp_q, rsp_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        cons_rd_q, cons_rd_d;
    logic        cons_valid_q, cons_valid_d;
    logic [7:0]  cons_data_q, cons_data_d;
    logic [31:0] ibus_data_q, ibus_iaddr_q;

    logic dreq, is_cons, if_rsp, drd_rsp;
    logic d_issue, wr_issue, rd_issue, f_issue;

    always_comb begin
        dreq     = iDbusWe | iDbusRead;
        is_cons  = (iDbusAddr == CONSOLE_ADDR);
        // A response in flight during reset is dropped.
        if_rsp   = ~rst & (rsp_q == RSP_IF);
        drd_rsp  = ~rst & (rsp_q == RSP_DRD);
        // The request being answered this cycle must not be issued again.
        d_issue  = ~rst & dreq & ~drd_rsp;
        wr_issue = d_issue & iDbusWe;
        rd_issue = d_issue & ~iDbusWe;
        f_issue  = ~rst & ~d_issue;
    end

    always_comb begin
        oMemWe     = wr_issue & ~is_cons;
        oMemRe     = (rd_issue & ~is_cons) | f_issue;
        oMemAddr   = d_issue ? iDbusAddr[MEM_AW-1:2] : iIbusAddr[MEM_AW-1:2];
        oMemByteEn = iDbusByteEn;
        oMemWData  = iDbusData;

        oDbusWait  = dreq & ~wr_issue & ~drd_rsp;
        oDbusData  = (drd_rsp & ~cons_rd_q) ? iMemRData : 32'h0;

        oIbusWait  = ~if_rsp;
        oIbusData  = if_rsp ? iMemRData    : ibus_data_q;
        oIbusIAddr = if_rsp ? fetch_addr_q : ibus_iaddr_q;

        oConsoleValid = cons_valid_q;
        oConsoleData  = cons_data_q;
    end

    always_comb begin
        rsp_d = RSP_NONE;
        if (rd_issue)
            rsp_d = RSP_DRD;
        else if (f_issue)
            rsp_d = RSP_IF;
        fetch_addr_d = f_issue ? iIbusAddr : fetch_addr_q;
        cons_rd_d    = rd_issue & is_cons;
        cons_valid_d = wr_issue & is_cons & iDbusByteEn[0];
        cons_data_d  = cons_valid_d ? iDbusData[7:0] : cons_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q        <= RSP_NONE;
            fetch_addr_q <= 32'h0;
            cons_rd_q    <= 1'b0;
            cons_valid_q <= 1'b0;
            cons_data_q  <= 8'h0;
            ibus_data_q  <= 32'h0;
            ibus_iaddr_q <= 32'h0;
        end else begin
            rsp_q        <= rsp_d;
            fetch_addr_q <= fetch_addr_d;
            cons_rd_q    <= cons_rd_d;
            cons_valid_q <= cons_valid_d;
            cons_data_q  <= cons_data_d;
            if (if_rsp) begin
                ibus_data_q  <= iMemRData;
                ibus_iaddr_q <= fetch_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_risac_mem_arbiter.sv
// Bench for risac_mem_arbiter: directed walk through the main scenarios, then
// randomized traffic, all checked against a transaction-level model with a shadow RAM.
module tb_risac_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iIbusAddr, oIbusData, oIbusIAddr;
    logic        oIbusWait;
    logic [31:0] iDbusAddr, iDbusData, oDbusData;
    logic        iDbusWe, iDbusRead, oDbusWait;
    logic [3:0]  iDbusByteEn, oMemByteEn;
    logic [9:0]  oMemAddr;
    logic        oMemRe, oMemWe;
    logic [31:0] oMemWData, iMemRData;
    logic        oConsoleValid;
    logic [7:0]  oConsoleData;

    always #5 clk = ~clk;

    risac_mem_arbiter #(.MEM_AW(12), .CONSOLE_ADDR(32'h0001_0000)) dut (
        .clk(clk), .rst(rst),
        .iIbusAddr(iIbusAddr), .oIbusData(oIbusData), .oIbusIAddr(oIbusIAddr), .oIbusWait(oIbusWait),
        .iDbusAddr(iDbusAddr), .iDbusWe(iDbusWe), .iDbusData(iDbusData), .iDbusRead(iDbusRead),
        .iDbusByteEn(iDbusByteEn), .oDbusData(oDbusData), .oDbusWait(oDbusWait),
        .oMemAddr(oMemAddr), .oMemRe(oMemRe), .oMemWe(oMemWe), .oMemByteEn(oMemByteEn),
        .oMemWData(oMemWData), .iMemRData(iMemRData),
        .oConsoleValid(oConsoleValid), .oConsoleData(oConsoleData)
    );

    function automatic logic [31:0] init_word(int i);
        case (i)
            0: return 32'h0000_0013;
            1: return 32'h0010_0093;
            2: return 32'h0020_0113;
            3: return 32'h0030_0193;
            default: return (32'(i) * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
        endcase
    endfunction

    // Single-port synchronous RAM macro stand-in.
    logic [31:0] ram [0:1023];
    logic        init_go;
    always @(posedge clk) begin
        if (init_go)
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
        if (oMemWe)
            for (int b = 0; b < 4; b++)
                if (oMemByteEn[b]) ram[oMemAddr][8*b +: 8] <= oMemWData[8*b +: 8];
        if (oMemRe) iMemRData <= ram[oMemAddr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transaction-level model state
    logic [31:0] ref_mem [0:1023];
    logic        pend_load, pend_cons, pend_fetch;
    logic [31:0] pend_ldata, pend_fdata, pend_faddr;
    logic        e_cval;
    logic [7:0]  e_cdata;
    logic        dreq, e_drd, e_if, e_iss, e_wr, e_rd, e_cons, e_memwe, e_memre, e_dwait;
    logic [9:0]  e_addr;

    task automatic sample();
        @(negedge clk);
        dreq    = iDbusWe | iDbusRead;
        e_drd   = !rst && pend_load;
        e_if    = !rst && pend_fetch;
        e_iss   = !rst && dreq && !e_drd;
        e_wr    = e_iss && iDbusWe;
        e_rd    = e_iss && !iDbusWe;
        e_cons  = (iDbusAddr == 32'h0001_0000);
        e_memwe = e_wr && !e_cons;
        e_memre = (e_rd && !e_cons) || (!rst && !e_iss);
        e_addr  = e_iss ? iDbusAddr[11:2] : iIbusAddr[11:2];
        e_dwait = dreq && !e_wr && !e_drd;
        chk("mem_we", 32'(oMemWe), 32'(e_memwe));
        chk("mem_re", 32'(oMemRe), 32'(e_memre));
        if (e_memwe || e_memre) chk("mem_addr", 32'(oMemAddr), 32'(e_addr));
        if (e_memwe) begin
            chk("mem_be", 32'(oMemByteEn), 32'(iDbusByteEn));
            chk("mem_wdata", oMemWData, iDbusData);
        end
        chk("dbus_wait", 32'(oDbusWait), 32'(e_dwait));
        if (e_drd) chk("dbus_data", oDbusData, pend_ldata);
        chk("ibus_wait", 32'(oIbusWait), 32'(!e_if));
        if (e_if) begin
            chk("ibus_data", oIbusData, pend_fdata);
            chk("ibus_iaddr", oIbusIAddr, pend_faddr);
        end
        chk("cons_valid", 32'(oConsoleValid), 32'(e_cval));
        if (e_cval) chk("cons_data", 32'(oConsoleData), 32'(e_cdata));
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            pend_load  = 1'b0;
            pend_fetch = 1'b0;
            e_cval     = 1'b0;
            e_cdata    = 8'h0;
        end else begin
            if (e_memwe)
                for (int b = 0; b < 4; b++)
                    if (iDbusByteEn[b]) ref_mem[iDbusAddr[11:2]][8*b +: 8] = iDbusData[8*b +: 8];
            pend_load  = e_rd;
            pend_cons  = e_cons;
            pend_ldata = e_cons ? 32'h0 : ref_mem[iDbusAddr[11:2]];
            pend_fetch = !e_iss;
            pend_faddr = iIbusAddr;
            pend_fdata = ref_mem[iIbusAddr[11:2]];
            e_cval     = e_wr && e_cons && iDbusByteEn[0];
            if (e_cval) e_cdata = iDbusData[7:0];
        end
        #1;
    endtask

    task automatic dbus(input logic we, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        iDbusWe = we; iDbusRead = rd; iDbusAddr = a; iDbusData = d; iDbusByteEn = be;
    endtask

    logic        h_active, h_we, h_rd;
    logic [31:0] h_addr, h_data, ra;
    logic [3:0]  h_be;
    int          kind;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        pend_load = 0; pend_cons = 0; pend_fetch = 0; pend_ldata = 0; pend_fdata = 0; pend_faddr = 0;
        e_cval = 0; e_cdata = 0;
        rst = 1'b1; init_go = 1'b1; iIbusAddr = 0;
        dbus(0, 0, 0, 0, 0);
        adv();
        init_go = 1'b0;
        sample(); adv();

        // Pipelined fetch out of reset
        rst = 1'b0; iIbusAddr = 0;
        sample(); chk("first_fetch_wait", 32'(oIbusWait), 32'd1); adv();
        iIbusAddr = 4;
        sample(); chk("f0_data", oIbusData, 32'h0000_0013); chk("f0_addr", oIbusIAddr, 32'd0); adv();
        iIbusAddr = 8;
        sample(); chk("f1_data", oIbusData, 32'h0010_0093); chk("f1_addr", oIbusIAddr, 32'd4); adv();
        iIbusAddr = 12;
        sample(); chk("f2_data", oIbusData, 32'h0020_0113); adv();

        // Store wins over fetch
        iIbusAddr = 16; dbus(1, 0, 32'h100, 32'hDEAD_BEEF, 4'hF);
        sample();
        chk("f3_data", oIbusData, 32'h0030_0193); chk("f3_addr", oIbusIAddr, 32'd12);
        chk("st_we", 32'(oMemWe), 32'd1); chk("st_addr", 32'(oMemAddr), 32'h40);
        chk("st_wait", 32'(oDbusWait), 32'd0); chk("st_nofetch", 32'(oMemRe), 32'd0);
        adv();

        // Load back; fetch issues during the response cycle
        dbus(0, 1, 32'h100, 0, 4'hF);
        sample(); chk("ld_ibus_wait", 32'(oIbusWait), 32'd1); chk("ld_wait", 32'(oDbusWait), 32'd1);
        chk("ld_re", 32'(oMemRe), 32'd1); adv();
        sample(); chk("ld_data", oDbusData, 32'hDEAD_BEEF); chk("ld_done", 32'(oDbusWait), 32'd0);
        chk("ld_fetch_re", 32'(oMemRe), 32'd1); chk("ld_fetch_addr", 32'(oMemAddr), 32'd4); adv();

        // Console write and read
        dbus(1, 0, 32'h0001_0000, 32'h0000_0041, 4'b0001);
        sample(); chk("con_we", 32'(oMemWe), 32'd0); chk("con_wait", 32'(oDbusWait), 32'd0); adv();
        dbus(0, 0, 0, 0, 0);
        sample(); chk("con_valid", 32'(oConsoleValid), 32'd1); chk("con_data", 32'(oConsoleData), 32'h41); adv();
        dbus(0, 1, 32'h0001_0000, 0, 4'hF);
        sample(); chk("con_valid_off", 32'(oConsoleValid), 32'd0); chk("con_rd_re", 32'(oMemRe), 32'd0); adv();
        sample(); chk("con_rd_data", oDbusData, 32'h0); chk("con_rd_wait", 32'(oDbusWait), 32'd0); adv();

        // Address aliasing
        dbus(1, 0, 32'h1100, 32'h1234_5678, 4'hF);
        sample(); chk("alias_addr", 32'(oMemAddr), 32'h40); chk("alias_we", 32'(oMemWe), 32'd1); adv();
        dbus(0, 1, 32'h100, 0, 4'hF);
        sample(); adv();
        sample(); chk("alias_rd", oDbusData, 32'h1234_5678); adv();
        dbus(0, 0, 0, 0, 0);
        sample(); adv();

        // Reset in the middle of a load
        dbus(0, 1, 32'h200, 0, 4'hF);
        sample(); adv();
        rst = 1'b1;
        sample(); chk("rst_dwait", 32'(oDbusWait), 32'd1); chk("rst_re", 32'(oMemRe), 32'd0); adv();
        rst = 1'b0;
        sample(); chk("rel_dwait", 32'(oDbusWait), 32'd1); chk("rel_addr", 32'(oMemAddr), 32'h80); adv();
        sample(); chk("rel_data", oDbusData, init_word(32'h80)); chk("rel_done", 32'(oDbusWait), 32'd0); adv();
        dbus(0, 0, 0, 0, 0);

        // Randomized traffic: the core holds each request until it sees it complete
        h_active = 1'b0; h_we = 0; h_rd = 0; h_addr = 0; h_data = 0; h_be = 0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            iIbusAddr = $urandom & 32'hFFFF_FFFC;
            if (!h_active && $urandom_range(0, 1) == 1) begin
                kind = int'($urandom_range(0, 9));
                ra = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 1) == 1) ra[31:12] = 20'h0;
                h_active = (kind != 9);
                h_we   = (kind >= 3 && kind <= 6) || kind == 8;
                h_rd   = (kind <= 2) || kind == 7 || kind == 8;
                h_addr = (kind == 6 || kind == 7) ? 32'h0001_0000 : ra;
                h_data = $urandom;
                h_be   = 4'($urandom_range(0, 15));
            end
            if (h_active) dbus(h_we, h_rd, h_addr, h_data, h_be);
            else          dbus(0, 0, $urandom, $urandom, 4'($urandom_range(0, 15)));
            sample();
            adv();
            if (h_active && !e_dwait) h_active = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
